// File: rtl/hazard_ctrl_param_pkg.sv
// Shared types and helpers for the hazard/forwarding controller: tracking-entry
// layout, forward-select width and encodings.
package hazard_ctrl_param_pkg;

  // Tracked destination addresses are zero-extended to this width; AW must not exceed it.
  localparam int RD_MAX_W = 8;

  // fwd_sel value meaning "read the register file"; k > 0 selects in-flight stage k.
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wen;
    logic                is_load;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '0;

  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_param_if.sv
// ID-stage hazard bus: instruction operands in, forward selects and pipeline controls out.
interface hazard_ctrl_param_if #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int SW      = 2
);
  logic                   id_valid;
  logic [NUM_SRC*AW-1:0]  id_rs;
  logic [NUM_SRC-1:0]     id_rs_used;
  logic [AW-1:0]          id_rd;
  logic                   id_wen;
  logic                   id_is_load;
  logic                   ex_branch_taken;
  logic [NUM_SRC*SW-1:0]  fwd_sel;
  logic                   stall;
  logic                   flush;
  logic [31:0]            stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_wen, id_is_load, ex_branch_taken,
    input  fwd_sel, stall, flush, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_wen, id_is_load, ex_branch_taken,
    output fwd_sel, stall, flush, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_param_src_match.sv
// One source operand against the in-flight tracking entries: youngest producer
// wins, and a load too young to forward flags a load-use hazard.
module hazard_src_match
  import hazard_ctrl_param_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 2,
  parameter int AW        = 5,
  parameter int SW        = 2
) (
  input  logic [AW-1:0] rs,
  input  logic          used,
  input  trk_entry_t    trk [1:FWD_DEPTH],
  output logic [SW-1:0] sel,
  output logic          load_hit
);

  logic [RD_MAX_W-1:0] rs_ext;
  logic [FWD_DEPTH:1]  hit;

  assign rs_ext = RD_MAX_W'(rs);

  generate
    for (genvar gi = 1; gi <= FWD_DEPTH; gi++) begin : g_hit
      assign hit[gi] = used && (rs != '0) && trk[gi].valid && trk[gi].wen &&
                       (trk[gi].rd == rs_ext);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel      = SW'(FWD_RF);
    load_hit = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (hit[k]) begin
        sel      = SW'(k);
        load_hit = trk[k].is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_param.sv
// Pipeline hazard controller: tracks in-flight writers, drives per-source forward
// selects, load-use stalls, branch flushes and a saturating stall counter.
module hazard_ctrl_param
  import hazard_ctrl_param_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_CYC = 2,
  parameter int AW        = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_ctrl_param_if.slave   hz
);

  localparam int SW = sel_width(FWD_DEPTH);
  localparam int CW = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);
  // The taken-branch cycle itself is the first flush cycle, so the counter holds the remainder.
  localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_CYC - 1);

  trk_entry_t            trk_reg [1:FWD_DEPTH];
  logic [CW-1:0]         flush_cnt_reg;
  logic [31:0]           stall_cnt_reg;
  logic                  rst_d_reg;

  trk_entry_t            id_entry;
  logic                  out_gate;
  logic                  flush_int;
  logic                  stall_int;
  logic [NUM_SRC-1:0]    load_hit;
  logic [NUM_SRC*SW-1:0] sel_raw;

  assign id_entry.valid   = hz.id_valid;
  assign id_entry.rd      = RD_MAX_W'(hz.id_rd);
  assign id_entry.wen     = hz.id_wen;
  assign id_entry.is_load = hz.id_is_load;

  // Controls stay quiet while reset is held and for one cycle after it releases.
  assign out_gate  = reset | rst_d_reg;
  assign flush_int = !out_gate && (hz.ex_branch_taken || (flush_cnt_reg != '0));
  assign stall_int = !out_gate && !flush_int && hz.id_valid && (|load_hit);

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      hazard_src_match #(
        .FWD_DEPTH (FWD_DEPTH),
        .LOAD_LAT  (LOAD_LAT),
        .AW        (AW),
        .SW        (SW)
      ) u_match (
        .rs       (hz.id_rs[gi*AW +: AW]),
        .used     (hz.id_rs_used[gi]),
        .trk      (trk_reg),
        .sel      (sel_raw[gi*SW +: SW]),
        .load_hit (load_hit[gi])
      );
    end
  endgenerate

  assign hz.fwd_sel   = out_gate ? '0 : sel_raw;
  assign hz.stall     = stall_int;
  assign hz.flush     = flush_int;
  assign hz.stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      trk_reg[1] <= TRK_BUBBLE;
    end else begin
      trk_reg[1] <= (stall_int || flush_int) ? TRK_BUBBLE : id_entry;
    end
  end

  generate
    for (genvar gi = 2; gi <= FWD_DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (reset) begin
          trk_reg[gi] <= TRK_BUBBLE;
        end else begin
          trk_reg[gi] <= trk_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_d_reg     <= 1'b1;
      flush_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      rst_d_reg <= 1'b0;
      if (hz.ex_branch_taken && !out_gate) begin
        flush_cnt_reg <= FLUSH_RELOAD;
      end else if (flush_cnt_reg != '0) begin
        flush_cnt_reg <= flush_cnt_reg - 1'b1;
      end
      if (stall_int && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: directed vector table and random traffic against a
// queue-based reference on the default build, plus a sequence on a deeper build.
module tb_hazard_ctrl_param;
  import hazard_ctrl_param_pkg::*;

  localparam int AW        = 5;
  localparam int FLUSH_CYC = 2;
  localparam int LL_A      = 2;
  localparam int DEPTH_A   = 3;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  hazard_ctrl_param_if #(.NUM_SRC(2), .AW(AW), .SW(2)) hza ();
  hazard_ctrl_param_if #(.NUM_SRC(3), .AW(AW), .SW(3)) hzb ();

  hazard_ctrl_param dut_a (.clk(clk), .reset(rst_a), .hz(hza));
  hazard_ctrl_param #(.NUM_SRC(3), .FWD_DEPTH(4), .LOAD_LAT(3), .FLUSH_CYC(2), .AW(AW))
    dut_b (.clk(clk), .reset(rst_b), .hz(hzb));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: a queue of the instructions that entered EX, youngest at index 0.
  typedef struct { bit v; int rd; bit wen; bit ld; } mrec_t;
  mrec_t       m_pipe[$];
  int          m_flush_left;
  int unsigned m_stall_cnt;
  bit          m_after_rst;

  task automatic model_clear();
    mrec_t b;
    b = '{v: 0, rd: 0, wen: 0, ld: 0};
    m_pipe.delete();
    for (int k = 0; k < DEPTH_A; k++) m_pipe.push_back(b);
    m_flush_left = 0;
    m_stall_cnt  = 0;
    m_after_rst  = 1;
  endtask

  task automatic model_eval(output int e_s0, output int e_s1, output bit e_st, output bit e_fl);
    bit gate;
    bit any_ld;
    int sel[2];
    gate   = rst_a || m_after_rst;
    e_fl   = !gate && (hza.ex_branch_taken || m_flush_left > 0);
    any_ld = 0;
    for (int i = 0; i < 2; i++) begin
      int rs;
      rs = int'((hza.id_rs >> (i*AW)) & 5'h1f);
      sel[i] = 0;
      if (hza.id_rs_used[i] && rs != 0) begin
        for (int k = 0; k < m_pipe.size(); k++) begin
          if (m_pipe[k].v && m_pipe[k].wen && m_pipe[k].rd == rs) begin
            sel[i] = k + 1;
            if (m_pipe[k].ld && (k + 1) < LL_A) any_ld = 1;
            break;
          end
        end
      end
    end
    e_s0 = gate ? 0 : sel[0];
    e_s1 = gate ? 0 : sel[1];
    e_st = !gate && !e_fl && hza.id_valid && any_ld;
  endtask

  task automatic model_commit(input bit st, input bit fl);
    mrec_t r;
    bit gate;
    if (rst_a) begin
      model_clear();
    end else begin
      gate = m_after_rst;
      if (st || fl) r = '{v: 0, rd: 0, wen: 0, ld: 0};
      else          r = '{v: hza.id_valid, rd: int'(hza.id_rd), wen: hza.id_wen, ld: hza.id_is_load};
      m_pipe.push_front(r);
      void'(m_pipe.pop_back());
      if (hza.ex_branch_taken && !gate) m_flush_left = FLUSH_CYC - 1;
      else if (m_flush_left > 0)        m_flush_left--;
      if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      m_after_rst = 0;
    end
  endtask

  task automatic drive_a(input bit rst, input bit v, input int rs0, input int rs1,
                         input bit [1:0] used, input int rd, input bit wen, input bit ld,
                         input bit br);
    rst_a               = rst;
    hza.id_valid        = v;
    hza.id_rs           = {AW'(rs1), AW'(rs0)};
    hza.id_rs_used      = used;
    hza.id_rd           = AW'(rd);
    hza.id_wen          = wen;
    hza.id_is_load      = ld;
    hza.ex_branch_taken = br;
  endtask

  typedef struct {
    bit rst; bit v; int rs0; int rs1; bit [1:0] used; int rd; bit wen; bit ld; bit br;
    int s0; int s1; bit st; bit fl; int cnt;
  } vec_t;

  function automatic vec_t mk(bit rst, bit v, int rs0, int rs1, bit [1:0] used, int rd,
                              bit wen, bit ld, bit br, int s0, int s1, bit st, bit fl, int cnt);
    vec_t t;
    t = '{rst: rst, v: v, rs0: rs0, rs1: rs1, used: used, rd: rd, wen: wen, ld: ld, br: br,
          s0: s0, s1: s1, st: st, fl: fl, cnt: cnt};
    return t;
  endfunction

  task automatic step_b(input string tag, input bit rst, input bit v, input int rs0,
                        input int rs1, input int rs2, input bit [2:0] used, input int rd,
                        input bit ld, input int s0, input int s1, input int s2,
                        input bit st, input int cnt);
    @(negedge clk);
    rst_b                = rst;
    hzb.id_valid         = v;
    hzb.id_rs            = {AW'(rs2), AW'(rs1), AW'(rs0)};
    hzb.id_rs_used       = used;
    hzb.id_rd            = AW'(rd);
    hzb.id_wen           = 1'b1;
    hzb.id_is_load       = ld;
    hzb.ex_branch_taken  = 1'b0;
    #1;
    check({tag, ".sel0"},  hzb.fwd_sel[2:0], s0);
    check({tag, ".sel1"},  hzb.fwd_sel[5:3], s1);
    check({tag, ".sel2"},  hzb.fwd_sel[8:6], s2);
    check({tag, ".stall"}, hzb.stall, st);
    check({tag, ".flush"}, hzb.flush, 0);
    check({tag, ".cnt"},   hzb.stall_cnt, cnt);
    $display("b %s: stall=%0b cnt=%0d sel=%0d/%0d/%0d", tag, hzb.stall, hzb.stall_cnt,
             hzb.fwd_sel[2:0], hzb.fwd_sel[5:3], hzb.fwd_sel[8:6]);
  endtask

  vec_t tbl[26];

  initial begin
    int e_s0, e_s1;
    bit e_st, e_fl;

    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_b = 1'b1;
    hzb.id_valid = 0; hzb.id_rs = '0; hzb.id_rs_used = '0; hzb.id_rd = '0;
    hzb.id_wen = 0; hzb.id_is_load = 0; hzb.ex_branch_taken = 0;
    repeat (2) @(posedge clk);
    model_clear();

    //         rst v rs0 rs1 used rd wen ld br | s0 s1 st fl cnt
    tbl[0]  = mk(1, 1,  5,  5, 3,  5, 1, 1, 1,   0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1,  1,  2, 3,  5, 1, 0, 1,   0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1,  5,  1, 3,  6, 1, 0, 0,   1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1,  5,  6, 3,  7, 1, 0, 0,   2, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1,  2,  7, 1,  8, 1, 1, 0,   0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1,  8,  8, 3,  9, 1, 0, 0,   1, 1, 1, 0, 0);
    tbl[6]  = mk(0, 1,  8,  8, 3,  9, 1, 0, 0,   2, 2, 0, 0, 1);
    tbl[7]  = mk(0, 1,  9,  0, 3,  0, 1, 0, 0,   1, 0, 0, 0, 1);
    tbl[8]  = mk(0, 1,  0,  0, 3, 10, 1, 0, 0,   0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1,  1,  0, 1,  3, 1, 1, 0,   0, 0, 0, 0, 1);
    tbl[10] = mk(0, 1,  4,  4, 3,  3, 1, 0, 0,   0, 0, 0, 0, 1);
    tbl[11] = mk(0, 1,  3, 10, 3, 11, 1, 0, 0,   1, 3, 0, 0, 1);
    tbl[12] = mk(0, 1, 11,  3, 3, 12, 1, 0, 1,   1, 2, 0, 1, 1);
    tbl[13] = mk(0, 1, 11, 12, 3, 13, 1, 0, 0,   2, 0, 0, 1, 1);
    tbl[14] = mk(0, 1, 11, 13, 3, 14, 1, 0, 0,   3, 0, 0, 0, 1);
    tbl[15] = mk(0, 1, 14,  0, 1, 15, 1, 0, 1,   1, 0, 0, 1, 1);
    tbl[16] = mk(0, 1, 14,  0, 1, 16, 1, 0, 1,   2, 0, 0, 1, 1);
    tbl[17] = mk(0, 1, 14,  0, 1, 17, 1, 0, 0,   3, 0, 0, 1, 1);
    tbl[18] = mk(0, 1, 14,  0, 1, 18, 1, 0, 0,   0, 0, 0, 0, 1);
    tbl[19] = mk(0, 1,  0,  0, 0, 20, 1, 1, 0,   0, 0, 0, 0, 1);
    tbl[20] = mk(0, 1, 20,  0, 1, 21, 1, 0, 1,   1, 0, 0, 1, 1);
    tbl[21] = mk(0, 1, 20,  0, 1, 21, 1, 0, 0,   2, 0, 0, 1, 1);
    tbl[22] = mk(0, 1, 20,  0, 1, 21, 1, 0, 1,   3, 0, 0, 1, 1);
    tbl[23] = mk(1, 1, 20,  0, 1, 21, 1, 0, 0,   0, 0, 0, 0, 1);
    tbl[24] = mk(0, 1, 20,  0, 1, 24, 1, 0, 1,   0, 0, 0, 0, 0);
    tbl[25] = mk(0, 1, 24,  0, 1, 25, 1, 0, 0,   1, 0, 0, 0, 0);

    for (int r = 0; r < 26; r++) begin
      string tag;
      tag = $sformatf("a%0d", r);
      @(negedge clk);
      drive_a(tbl[r].rst, tbl[r].v, tbl[r].rs0, tbl[r].rs1, tbl[r].used, tbl[r].rd,
              tbl[r].wen, tbl[r].ld, tbl[r].br);
      #1;
      model_eval(e_s0, e_s1, e_st, e_fl);
      check({tag, ".sel0"},  hza.fwd_sel[1:0], tbl[r].s0);
      check({tag, ".sel1"},  hza.fwd_sel[3:2], tbl[r].s1);
      check({tag, ".stall"}, hza.stall, tbl[r].st);
      check({tag, ".flush"}, hza.flush, tbl[r].fl);
      check({tag, ".cnt"},   hza.stall_cnt, tbl[r].cnt);
      $display("a %s: sel=%0d/%0d stall=%0b flush=%0b cnt=%0d", tag, hza.fwd_sel[1:0],
               hza.fwd_sel[3:2], hza.stall, hza.flush, hza.stall_cnt);
      @(posedge clk);
      model_commit(e_st, e_fl);
    end

    for (int c = 0; c < 400; c++) begin
      string tag;
      tag = $sformatf("r%0d", c);
      @(negedge clk);
      drive_a($urandom_range(59) == 0, $urandom_range(3) != 0, int'($urandom_range(7)),
              int'($urandom_range(7)), 2'($urandom_range(3)), int'($urandom_range(7)),
              $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(9) == 0);
      #1;
      model_eval(e_s0, e_s1, e_st, e_fl);
      check({tag, ".sel0"},  hza.fwd_sel[1:0], e_s0);
      check({tag, ".sel1"},  hza.fwd_sel[3:2], e_s1);
      check({tag, ".stall"}, hza.stall, e_st);
      check({tag, ".flush"}, hza.flush, e_fl);
      check({tag, ".cnt"},   hza.stall_cnt, m_stall_cnt);
      $display("a %s: sel=%0d/%0d stall=%0b flush=%0b cnt=%0d", tag, hza.fwd_sel[1:0],
               hza.fwd_sel[3:2], hza.stall, hza.flush, hza.stall_cnt);
      @(posedge clk);
      model_commit(e_st, e_fl);
    end

    // Deeper build: a load needs two bubbles, and reset mid-stall leaves nothing behind.
    //     tag  rst v rs0 rs1 rs2 used rd ld | s0 s1 s2 st cnt
    step_b("b0",  1, 1, 7, 7, 0, 3'b111, 7, 1,  0, 0, 0, 0, 0);
    step_b("b1",  0, 1, 0, 0, 0, 3'b000, 7, 1,  0, 0, 0, 0, 0);
    step_b("b2",  0, 1, 7, 7, 0, 3'b111, 8, 0,  1, 1, 0, 1, 0);
    step_b("b3",  0, 1, 7, 7, 0, 3'b111, 8, 0,  2, 2, 0, 1, 1);
    step_b("b4",  0, 1, 7, 7, 0, 3'b111, 8, 0,  3, 3, 0, 0, 2);
    step_b("b5",  0, 0, 7, 7, 8, 3'b111, 8, 0,  4, 4, 1, 0, 2);
    step_b("b6",  0, 1, 0, 0, 0, 3'b000, 9, 1,  0, 0, 0, 0, 2);
    step_b("b7",  0, 1, 9, 0, 0, 3'b001, 10, 0, 1, 0, 0, 1, 2);
    step_b("b8",  1, 1, 9, 0, 0, 3'b001, 10, 0, 0, 0, 0, 0, 3);
    step_b("b9",  0, 1, 9, 0, 0, 3'b001, 10, 0, 0, 0, 0, 0, 0);
    step_b("b10", 0, 0, 9, 0, 0, 3'b001, 11, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
